tt_um_sequence_generator: RTL and testbench
===========================================

// Module: tt_um_sequence_generator
// PURPOSE
//  Serial pattern transmitter: source side of the single-bit stream consumed by the sequence detector.
//  Latches an 8-bit pattern and emits 1..8 bits LSB-first on one wire, with a bit strobe, busy and done flags.
//  Keeps a running ones-count mod ONES_MOD and pulses mod_match on each wrap, giving the expected detector output.
//  Standalone TT user tile; the detector input ui_in[0] is wired to uo_out[0] externally.
// PARAMETERS
//  ONES_MOD    3  modulus of the running ones counter (2..4); matches the detector's count.
//  REPEAT_GAP  0  idle cycles inserted between repeated bursts (0..15).
// PORTS
//  clk      in   1  clock; all state updates on the rising edge.
//  rst_n    in   1  synchronous, active-low reset.
//  ena      in   1  tile enable; no functional effect (design is gated by rst_n).
//  ui_in    in   8  pattern byte; bit 0 is sent first.
//  uio_in   in   8  [2:0] len-1 (1..8 bits), [3] start, [4] repeat, [5] prbs_sel, [7:6] period sel.
//  uo_out   out  8  [0] sdata, [1] bit_valid, [2] busy, [3] done, [4] mod_match, [6:5] ones_cnt, [7] 0.
//  uio_out  out  8  constant 0.
//  uio_oe   out  8  constant 0 (all uio pins are inputs).
// BEHAVIOUR
//  - All uo_out bits are registered. Reset (rst_n=0 at an edge): state=IDLE and all uo_out=0 after that edge.
//    Reset mid-burst aborts the burst immediately; no done pulse.
//  - Period: uio_in[7:6] 0/1/2/3 -> each bit is held for 1/2/4/8 cycles.
//  - start_rise = start=1 at this edge AND start=0 at the previous edge (start_d register, reset 0).
//  - States: IDLE, SHIFT, GAP, DONE.
//  - IDLE: on start_rise, capture pattern, len, period and repeat into shadow registers.
//    Clear bit_idx, the period counter and ones_cnt. Go to SHIFT.
//    Input changes after capture have no effect until the next capture.
//  - SHIFT: sdata = shadow[bit_idx]. bit_valid=1 only on the first cycle of each bit. busy=1.
//    First bit is visible after the edge that sampled start_rise, so latency is 1 cycle.
//  - End of the last bit period (bit_idx==len-1):
//    - repeat latched AND start still 1: go to GAP if REPEAT_GAP>0, else directly to SHIFT with bit_idx=0.
//    - otherwise: go to DONE.
//  - GAP: sdata=0, bit_valid=0, busy=1, held for REPEAT_GAP cycles, then SHIFT with bit_idx=0.
//    ones_cnt is not cleared across repeats.
//  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//    A start_rise in DONE is ignored; restart needs a fresh rise in IDLE.
//  - start_rise while in SHIFT or GAP is ignored; it never restarts the burst.
//  - Ones counter: on a bit_valid cycle with sdata=1, ones_cnt increments.
//    On reaching ONES_MOD it wraps to 0, and mod_match=1 on that same cycle.
//    mod_match is otherwise 0. With ONES_MOD=4, ones_cnt spans 0..3 in 2 bits.
//  - len field 3'b111 means 8 bits; len 3'b000 means 1 bit.
//  - In IDLE: sdata=0, bit_valid=0, busy=0.
// CONFIGURATION
//  SEQGEN_LFSR_EN defined:
//    - prbs_sel=1 at capture selects PRBS7 (x^7+x^6+1) mode.
//    - LFSR seed = ui_in[6:0]; a zero seed is forced to 7'h7F. The LFSR steps once per emitted bit.
//    - sdata = LFSR bit 0. len is ignored: the stream runs until start=0 at a bit boundary, then DONE.
//  SEQGEN_LFSR_EN undefined:
//    - uio_in[5] is ignored and no LFSR logic is generated.
// TESTING
//  1. rst_n=0 for 2 cycles, then 1 -> uo_out=8'h00, uio_oe=8'h00. Hold until start is applied.
//  2. ui_in=8'hB5, len=3'b111, period=0, start rise ->
//     sdata = 1,0,1,0,1,1,0,1 on consecutive cycles, bit_valid=1 each cycle, then done=1 for 1 cycle.
//  3. ui_in=8'h07, len=3'b010, period=2 (4 cycles per bit) ->
//     three 1-bits, each held 4 cycles. mod_match=1 on the 3rd bit's first cycle; ones_cnt ends at 0.
//  4. repeat=1, start held, ui_in=8'h01, len=0, REPEAT_GAP=2 -> bit_valid every 3 cycles.
//     mod_match on every 3rd burst. Drop start -> done after the current burst.
//  5. rst_n=0 during bit 4 of an 8-bit burst -> busy=0 and sdata=0 after the edge, no done.
//     A start rise during SHIFT is ignored.
//  6. SEQGEN_LFSR_EN, prbs_sel=1, seed 0 -> seed forced to 7'h7F.
//     The sequence matches the reference PRBS7 for 127 bits and repeats with period 127.

Source files
------------

// File: rtl/tt_um_sequence_generator.sv
// tt_um_sequence_generator
// Serial pattern transmitter feeding the sequence detector tile. It captures a
// pattern byte and sends 1..8 bits LSB-first on uo_out[0]. Each bit has a
// one-cycle strobe. The block also drives busy/done flags and a running
// ones-count mod ONES_MOD, with a pulse on every wrap.
// Optional feature: define SEQGEN_LFSR_EN to add the PRBS7 (x^7+x^6+1) source.
//
// state   | meaning
// S_IDLE  | waiting for a start rise; all stream outputs quiet
// S_SHIFT | emitting captured pattern (or PRBS7), one bit per period
// S_GAP   | REPEAT_GAP idle cycles between repeated bursts, still busy
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module tt_um_sequence_generator #(
    parameter int ONES_MOD   = 3,
    parameter int REPEAT_GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    localparam bit         HAS_GAP  = (REPEAT_GAP > 0);
    localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(REPEAT_GAP - 1) : 4'd0;

    state_t     state_q;
    logic       start_q;
    logic [7:0] pat_q;
    logic [2:0] len_q;
    logic [1:0] per_q;
    logic       rpt_q;
    logic [2:0] bit_idx_q;
    logic [2:0] per_cnt_q;
    logic [3:0] gap_cnt_q;
    logic [1:0] ones_q;
    logic       sdata_q;
    logic       bv_q;
    logic       busy_q;
    logic       done_q;
    logic       match_q;

    logic       start_rise_d;
    logic       boundary_d;
    logic       last_d;
    logic       cont_d;
    logic       gap_go_d;
    logic       cap_bit_d;
    logic       nxt_bit_d;
    logic [2:0] nxt_idx_d;
    logic [2:0] ones_cap_d;
    logic [2:0] ones_nxt_d;

    logic       unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[5]};

    // Per-bit down-counter reload: period of 1/2/4/8 cycles.
    function automatic logic [2:0] per_load(input logic [1:0] sel);
        case (sel)
            2'd0:    per_load = 3'd0;
            2'd1:    per_load = 3'd1;
            2'd2:    per_load = 3'd3;
            default: per_load = 3'd7;
        endcase
    endfunction

    // Ones counter step; bit 2 of the result flags a wrap (mod_match).
    function automatic logic [2:0] ones_step(input logic [1:0] cnt, input logic b);
        logic [2:0] inc;
        inc = {1'b0, cnt} + 3'd1;
        if (!b)
            ones_step = {1'b0, cnt};
        else if (inc == 3'(ONES_MOD))
            ones_step = 3'b100;
        else
            ones_step = {1'b0, inc[1:0]};
    endfunction

`ifdef SEQGEN_LFSR_EN
    logic       prbs_q;
    logic [6:0] lfsr_q;
    logic [6:0] seed_d;
    logic [6:0] lfsr_nxt_d;

    assign seed_d     = (ui_in[6:0] == 7'd0) ? 7'h7F : ui_in[6:0];
    assign lfsr_nxt_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    // PRBS7 register: seeded at capture, steps once per emitted bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prbs_q <= 1'b0;
            lfsr_q <= 7'h7F;
        end else if (state_q == S_IDLE && start_rise_d) begin
            prbs_q <= uio_in[5];
            lfsr_q <= seed_d;
        end else if (state_q == S_SHIFT && boundary_d && cont_d) begin
            lfsr_q <= lfsr_nxt_d;
        end
    end
`endif

    // Decide what happens at the end of the current bit and which bit comes next.
    always_comb begin
        start_rise_d = uio_in[3] & ~start_q;
        boundary_d   = (per_cnt_q == 3'd0);
        last_d       = (bit_idx_q == len_q);
        nxt_idx_d    = last_d ? 3'd0 : bit_idx_q + 3'd1;
        nxt_bit_d    = pat_q[nxt_idx_d];
        cap_bit_d    = ui_in[0];
        cont_d       = 1'b0;
        gap_go_d     = 1'b0;
        if (!last_d) begin
            cont_d = 1'b1;
        end else if (rpt_q && uio_in[3]) begin
            if (HAS_GAP)
                gap_go_d = 1'b1;
            else
                cont_d = 1'b1;
        end
`ifdef SEQGEN_LFSR_EN
        // PRBS mode ignores len: keep going while start is held.
        if (prbs_q) begin
            nxt_bit_d = lfsr_nxt_d[0];
            cont_d    = uio_in[3];
            gap_go_d  = 1'b0;
        end
        if (uio_in[5])
            cap_bit_d = seed_d[0];
`endif
        ones_cap_d = ones_step(2'd0, cap_bit_d);
        ones_nxt_d = ones_step(ones_q, nxt_bit_d);
    end

    // Sequencer FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            pat_q     <= 8'd0;
            len_q     <= 3'd0;
            per_q     <= 2'd0;
            rpt_q     <= 1'b0;
            bit_idx_q <= 3'd0;
            per_cnt_q <= 3'd0;
            gap_cnt_q <= 4'd0;
            ones_q    <= 2'd0;
            sdata_q   <= 1'b0;
            bv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            start_q <= uio_in[3];
            bv_q    <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    sdata_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start_rise_d) begin
                        pat_q     <= ui_in;
                        len_q     <= uio_in[2:0];
                        per_q     <= uio_in[7:6];
                        rpt_q     <= uio_in[4];
                        bit_idx_q <= 3'd0;
                        per_cnt_q <= per_load(uio_in[7:6]);
                        sdata_q   <= cap_bit_d;
                        bv_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        ones_q    <= ones_cap_d[1:0];
                        match_q   <= ones_cap_d[2];
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!boundary_d) begin
                        per_cnt_q <= per_cnt_q - 3'd1;
                    end else if (cont_d) begin
                        bit_idx_q <= nxt_idx_d;
                        per_cnt_q <= per_load(per_q);
                        sdata_q   <= nxt_bit_d;
                        bv_q      <= 1'b1;
                        ones_q    <= ones_nxt_d[1:0];
                        match_q   <= ones_nxt_d[2];
                    end else if (gap_go_d) begin
                        gap_cnt_q <= GAP_LOAD;
                        sdata_q   <= 1'b0;
                        state_q   <= S_GAP;
                    end else begin
                        sdata_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != 4'd0) begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end else begin
                        bit_idx_q <= nxt_idx_d;
                        per_cnt_q <= per_load(per_q);
                        sdata_q   <= nxt_bit_d;
                        bv_q      <= 1'b1;
                        ones_q    <= ones_nxt_d[1:0];
                        match_q   <= ones_nxt_d[2];
                        state_q   <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {1'b0, ones_q, match_q, done_q, busy_q, bv_q, sdata_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_sequence_generator.sv
// Directed bench for tt_um_sequence_generator (ONES_MOD=3, REPEAT_GAP=2).
// uo_out byte = {0, ones[1:0], mod_match, done, busy, bit_valid, sdata}.
module tb_tt_um_sequence_generator;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk = 0;
    int n_err = 0;

    tt_um_sequence_generator #(
        .ONES_MOD   (3),
        .REPEAT_GAP (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // 8'hB5, 8 bits, period 1: bits 1,0,1,0,1,1,0,1 then done
    logic [7:0] exp2 [9]  = '{8'h27, 8'h26, 8'h47, 8'h46, 8'h17, 8'h27, 8'h26, 8'h47, 8'h48};
    // 8'h07, 3 bits, period 4
    logic [7:0] exp3 [14] = '{8'h27, 8'h25, 8'h25, 8'h25, 8'h47, 8'h45, 8'h45, 8'h45,
                              8'h17, 8'h05, 8'h05, 8'h05, 8'h08, 8'h00};
    // 1-bit repeated bursts with 2-cycle gap
    logic [7:0] exp4 [10] = '{8'h27, 8'h24, 8'h24, 8'h47, 8'h44, 8'h44, 8'h17, 8'h04, 8'h04, 8'h27};

    initial begin
        // reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_uo", uo_out, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("rst_release_uo", uo_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);
        chk("uio_out", uio_out, 8'h00);

        // 8-bit burst, inputs changed after capture
        ui_in  = 8'hB5;
        uio_in = 8'h07;
        tick();
        chk("idle_pre", uo_out, 8'h00);
        uio_in = 8'h0F;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("b5_%0d", i), uo_out, exp2[i]);
            ui_in  = 8'h00;
            uio_in = 8'h00;
        end
        uio_in = 8'h08;
        tick();
        chk("done_rise_ign", uo_out, 8'h40);
        tick();
        chk("idle_hold", uo_out, 8'h40);
        uio_in = 8'h00;
        tick();

        // period 4, ones wrap
        ui_in  = 8'h07;
        uio_in = 8'h82;
        tick();
        uio_in = 8'h8A;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("p4_%0d", i), uo_out, exp3[i]);
            ui_in  = 8'h00;
            uio_in = 8'h00;
        end

        // repeat with gap, start held
        ui_in  = 8'h01;
        uio_in = 8'h10;
        tick();
        uio_in = 8'h18;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("rep_%0d", i), uo_out, exp4[i]);
        end
        uio_in = 8'h10;
        tick();
        chk("rep_done", uo_out, 8'h28);
        tick();
        chk("rep_idle", uo_out, 8'h20);

        // start rise in SHIFT ignored, then reset mid-burst
        ui_in  = 8'hFF;
        uio_in = 8'h07;
        tick();
        uio_in = 8'h0F;
        tick();
        chk("ff_b0", uo_out, 8'h27);
        uio_in = 8'h07;
        tick();
        chk("ff_b1", uo_out, 8'h47);
        uio_in = 8'h0F;
        tick();
        chk("ff_b2_rise", uo_out, 8'h17);
        tick();
        chk("ff_b3", uo_out, 8'h27);
        rst_n  = 1'b0;
        uio_in = 8'h07;
        tick();
        chk("midrst", uo_out, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("midrst_nodone0", uo_out, 8'h00);
        tick();
        chk("midrst_nodone1", uo_out, 8'h00);

`ifdef SEQGEN_LFSR_EN
        begin : prbs_blk
            logic [6:0] l;
            l      = 7'h7F;
            ui_in  = 8'h00;
            uio_in = 8'h20;
            tick();
            uio_in = 8'h28;
            for (int i = 0; i < 254; i++) begin
                tick();
                chk($sformatf("prbs_%0d", i), {7'd0, uo_out[0]}, {7'd0, l[0]});
                l = {l[5:0], l[6] ^ l[5]};
            end
            uio_in = 8'h20;
            tick();
            chk("prbs_done", {6'd0, uo_out[3:2]}, 8'h02);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
